status_type2_merger: RTL



---
 rtl/status_pkg.sv | 14 +
 rtl/status_sync_fifo.sv | 62 ++++++
 rtl/status_type2_merger.sv | 126 ++++++++++++
 3 files changed

// File: rtl/status_pkg.sv
// Shared constants and entry layout for the type-2 status merger.
// Entry is {id, info}: id names the source channel of the status word.
package status_pkg;

    localparam int STATUS_W = 64;
    localparam int NUM_CH   = 4;
    localparam int ID_W     = 2;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [STATUS_W-1:0] info;
    } status_entry_t;

endpackage

// File: rtl/status_sync_fifo.sv
// Show-ahead synchronous FIFO, async active-low reset.
// Ports: push/wdata in, pop in, rdata (head, 0 when empty), full, empty, count.
module status_sync_fifo #(
    parameter  int WIDTH = 66,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Head is forced to zero while empty so nothing stale is ever visible.
    assign rdata = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= wdata;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/status_type2_merger.sv
// Captures up to four type-2 status words, drains them round-robin into a tagged FIFO.
// Ports: info/valid_type2_id0..3 in, module2_busy out, out_info/out_id/out_valid out, out_ready in.
module status_type2_merger
    import status_pkg::*;
#(
    parameter int DATA_W     = STATUS_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] info_type2_id0,
    input  logic [DATA_W-1:0] info_type2_id1,
    input  logic [DATA_W-1:0] info_type2_id2,
    input  logic [DATA_W-1:0] info_type2_id3,
    input  logic              valid_type2_id0,
    input  logic              valid_type2_id1,
    input  logic              valid_type2_id2,
    input  logic              valid_type2_id3,
    output logic              module2_busy,
    output logic [DATA_W-1:0] out_info,
    output logic [ID_W-1:0]   out_id,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int EW = ID_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] r_data [NUM_CH];
    logic [NUM_CH-1:0] r_occ;
    logic [ID_W-1:0]   r_rr;
    logic              r_busy;

    logic [DATA_W-1:0] w_info [NUM_CH];
    logic [NUM_CH-1:0] w_vld;
    logic [NUM_CH-1:0] w_occ_nxt;
    logic [ID_W-1:0]   w_gnt;
    logic              w_any;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [EW-1:0]     w_wdata;
    logic [EW-1:0]     w_rdata;
    logic [CW-1:0]     w_count;
    logic              w_unused;

    assign w_info[0] = info_type2_id0;
    assign w_info[1] = info_type2_id1;
    assign w_info[2] = info_type2_id2;
    assign w_info[3] = info_type2_id3;
    assign w_vld     = {valid_type2_id3, valid_type2_id2,
                        valid_type2_id1, valid_type2_id0};

    // First occupied slot at or after r_rr; descending scan lets the
    // smallest offset win.
    always_comb begin
        w_gnt = r_rr;
        w_any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_occ[r_rr + ID_W'(i)]) begin
                w_gnt = r_rr + ID_W'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = w_any & (~w_full | w_pop);
    assign w_wdata = {w_gnt, r_data[w_gnt]};

    // Capture only happens while not busy, i.e. with every slot already empty.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_push) begin
            w_occ_nxt[w_gnt] = 1'b0;
        end
        if (!r_busy) begin
            w_occ_nxt = w_occ_nxt | w_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= '0;
            r_rr   <= '0;
            r_busy <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_data[c] <= '0;
            end
        end else begin
            r_occ  <= w_occ_nxt;
            r_busy <= |w_occ_nxt;
            if (w_push) begin
                r_rr <= w_gnt + ID_W'(1);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!r_busy && w_vld[c]) begin
                    r_data[c] <= w_info[c];
                end
            end
        end
    end

    status_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_unused     = ^w_count;
    assign module2_busy = r_busy;
    assign out_valid    = ~w_empty;
    assign out_id       = w_rdata[EW-1 -: ID_W];
    assign out_info     = w_rdata[DATA_W-1:0];

endmodule
